// File: rtl/dma_write_engine.sv
`default_nettype none
// ============================================================================
// Module   : dma_write_engine (plus dma_write_engine_pkg)
// Brief    : Streaming DMA writer for the CCI-P c1 channel. Turns a
//            valid/ready stream of 512-bit lines into WrLine_I requests at
//            consecutive VA cache-line addresses. It can append a WrFence and
//            pulses done once every request has been acknowledged.
// Revision : 1.0  initial release
// ============================================================================

package dma_write_engine_pkg;

  // Subset of the CCI-P c1 request/response types used by this engine
  typedef logic [41:0]  t_ccip_clAddr;
  typedef logic [15:0]  t_ccip_mdata;
  typedef logic [511:0] t_ccip_clData;

  typedef enum logic [1:0] {
    eVC_VA  = 2'h0,
    eVC_VL0 = 2'h1,
    eVC_VH0 = 2'h2,
    eVC_VH1 = 2'h3
  } t_ccip_vc;

  typedef enum logic [1:0] {
    eCL_LEN_1 = 2'h0,
    eCL_LEN_2 = 2'h1,
    eCL_LEN_4 = 2'h3
  } t_ccip_clLen;

  typedef enum logic [3:0] {
    eREQ_WRLINE_I = 4'h0,
    eREQ_WRLINE_M = 4'h1,
    eREQ_WRPUSH_I = 4'h2,
    eREQ_WRFENCE  = 4'h4,
    eREQ_INTR     = 4'h6
  } t_ccip_c1_req;

  typedef struct packed {
    logic [5:0]   rsvd2;
    t_ccip_vc     vc_sel;
    logic         sop;
    logic         rsvd1;
    t_ccip_clLen  cl_len;
    t_ccip_c1_req req_type;
    logic [5:0]   rsvd0;
    t_ccip_clAddr address;
    t_ccip_mdata  mdata;
  } t_ccip_c1_ReqMemHdr;

  typedef struct packed {
    t_ccip_c1_ReqMemHdr hdr;
    t_ccip_clData       data;
    logic               valid;
  } t_if_ccip_c1_Tx;

  typedef struct packed {
    t_ccip_vc    vc_used;
    logic        rsvd1;
    logic        hit_miss;
    logic        format;
    logic        rsvd0;
    logic [1:0]  cl_num;
    logic [3:0]  resp_type;
    t_ccip_mdata mdata;
  } t_ccip_c1_RspMemHdr;

  typedef struct packed {
    t_ccip_c1_RspMemHdr hdr;
    logic               rspValid;
  } t_if_ccip_c1_Rx;

endpackage

module dma_write_engine
  import dma_write_engine_pkg::*;
#(
  parameter int RSP_CNT_WIDTH = 32,
  parameter int ALMFULL_STALL = 1
) (
  input  logic           clk,
  input  logic           reset,
  input  t_ccip_clAddr   dst_addr,
  input  logic [31:0]    dst_ncl,
  input  logic           fence_at_end,
  input  logic           start,
  input  logic [511:0]   in_data,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic           c1TxAlmFull,
  output t_if_ccip_c1_Tx c1tx,
  input  t_if_ccip_c1_Rx c1rx,
  output logic           busy,
  output logic           done,
  output logic [31:0]    words_written,
  output logic [3:0]     state_out
);

  localparam logic [3:0] S_IDLE  = 4'd0;
  localparam logic [3:0] S_WRITE = 4'd1;
  localparam logic [3:0] S_FENCE = 4'd2;
  localparam logic [3:0] S_DRAIN = 4'd3;
  localparam logic [3:0] S_DONE  = 4'd4;

  logic [3:0]               state_q,   state_d;
  t_ccip_clAddr             base_q,    base_d;
  logic [31:0]              ncl_q,     ncl_d;
  logic                     fence_q,   fence_d;
  logic [31:0]              words_q,   words_d;
  logic [RSP_CNT_WIDTH-1:0] req_cnt_q, req_cnt_d;
  logic [RSP_CNT_WIDTH-1:0] rsp_cnt_q, rsp_cnt_d;
  logic                     match_q,   match_d;
  logic                     done_q,    done_d;
  t_if_ccip_c1_Tx           c1tx_q,    c1tx_d;

  logic w_stall;
  logic w_in_ready;
  logic w_accept;
  logic w_unused_rx_hdr;

  // Only the response strobe matters; header contents are not tracked
  assign w_unused_rx_hdr = ^c1rx.hdr;

  assign w_stall    = (ALMFULL_STALL != 0) && c1TxAlmFull;
  assign w_in_ready = (state_q == S_WRITE) && (words_q < ncl_q) && !w_stall;
  assign w_accept   = in_valid && w_in_ready;

  // Next-state, request formation and response counting
  always_comb begin
    state_d   = state_q;
    base_d    = base_q;
    ncl_d     = ncl_q;
    fence_d   = fence_q;
    words_d   = words_q;
    req_cnt_d = req_cnt_q;
    rsp_cnt_d = rsp_cnt_q;
    c1tx_d    = '0;
    done_d    = (state_q == S_DONE);
    // Compare is registered, so DRAIN exits one cycle after counts meet;
    // gating with DRAIN keeps a stale match from an earlier state out.
    match_d   = (state_q == S_DRAIN) && (rsp_cnt_q == req_cnt_q);

    if (c1rx.rspValid && (state_q != S_IDLE)) begin
      rsp_cnt_d = rsp_cnt_q + RSP_CNT_WIDTH'(1);
    end

    case (state_q)
      S_IDLE: begin
        if (start) begin
          base_d    = dst_addr;
          ncl_d     = dst_ncl;
          fence_d   = fence_at_end;
          words_d   = '0;
          req_cnt_d = '0;
          rsp_cnt_d = '0;
          if (dst_ncl != 32'd0) begin
            state_d = S_WRITE;
          end else if (fence_at_end) begin
            state_d = S_FENCE;
          end else begin
            state_d = S_DONE;
          end
        end
      end
      S_WRITE: begin
        if (w_accept) begin
          c1tx_d.valid         = 1'b1;
          c1tx_d.hdr.sop       = 1'b1;
          c1tx_d.hdr.vc_sel    = eVC_VA;
          c1tx_d.hdr.cl_len    = eCL_LEN_1;
          c1tx_d.hdr.req_type  = eREQ_WRLINE_I;
          c1tx_d.hdr.address   = base_q + t_ccip_clAddr'(words_q);
          c1tx_d.hdr.mdata     = words_q[15:0];
          c1tx_d.data          = in_data;
          words_d              = words_q + 32'd1;
          req_cnt_d            = req_cnt_q + RSP_CNT_WIDTH'(1);
          if (words_q == (ncl_q - 32'd1)) begin
            state_d = fence_q ? S_FENCE : S_DRAIN;
          end
        end
      end
      S_FENCE: begin
        if (!w_stall) begin
          c1tx_d.valid        = 1'b1;
          c1tx_d.hdr.vc_sel   = eVC_VA;
          c1tx_d.hdr.req_type = eREQ_WRFENCE;
          req_cnt_d           = req_cnt_q + RSP_CNT_WIDTH'(1);
          state_d             = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (match_q) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      base_q    <= '0;
      ncl_q     <= '0;
      fence_q   <= 1'b0;
      words_q   <= '0;
      req_cnt_q <= '0;
      rsp_cnt_q <= '0;
      match_q   <= 1'b0;
      done_q    <= 1'b0;
      c1tx_q    <= '0;
    end else begin
      state_q   <= state_d;
      base_q    <= base_d;
      ncl_q     <= ncl_d;
      fence_q   <= fence_d;
      words_q   <= words_d;
      req_cnt_q <= req_cnt_d;
      rsp_cnt_q <= rsp_cnt_d;
      match_q   <= match_d;
      done_q    <= done_d;
      c1tx_q    <= c1tx_d;
    end
  end

  assign in_ready      = w_in_ready;
  assign c1tx          = c1tx_q;
  assign busy          = (state_q != S_IDLE);
  assign done          = done_q;
  assign words_written = words_q;
  assign state_out     = state_q;

endmodule

`default_nettype wire

// File: doc/dma_write_engine.md
Name: dma_write_engine

Overview:
Streaming DMA writer for the CCI-P c1 channel; it is the write-side counterpart of dma_read_engine.
- Accepts a valid/ready stream of 512-bit cache lines and writes them to dst_addr .. dst_addr+dst_ncl-1 as WrLine_I requests on VA.
- Optionally appends a write fence.
- Counts c1 write responses and pulses done only when every request, fence included, is acknowledged.
- Sits between SSSP-style producers (update-bin writers) and the application top's c1 Tx path.

Parameters:
- RSP_CNT_WIDTH, 32, width of the request and response counters.
- ALMFULL_STALL, 1, when 1, in_ready and fence issue are gated by c1TxAlmFull; when 0, the external FIFO handles backpressure.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- dst_addr  in  t_ccip_clAddr (42)  first destination cache-line address; sampled on start
- dst_ncl  in  32  number of lines to write; sampled on start
- fence_at_end  in  1  issue a WrFence after the last line; sampled on start
- start  in  1  one-cycle request pulse; honoured only in IDLE
- in_data  in  512  line payload
- in_valid  in  1  payload valid
- in_ready  out  1  payload accepted when in_valid & in_ready
- c1TxAlmFull  in  1  c1 almost-full from the FIU side
- c1tx  out  t_if_ccip_c1_Tx  write and fence requests, registered
- c1rx  in  t_if_ccip_c1_Rx  write responses; only rspValid is used
- busy  out  1  high in any state other than IDLE
- done  out  1  one-cycle pulse when the job is fully acknowledged
- words_written  out  32  lines issued in the current or last job
- state_out  out  4  encoded FSM state, for CSR debug

Behaviour:
Reset values:
- State IDLE; c1tx is all zero (valid 0); in_ready 0; done 0; busy 0; all counters 0.

States: IDLE(0), WRITE(1), FENCE(2), DRAIN(3), DONE(4).
- IDLE:
  - On start: latch dst_addr, dst_ncl and fence_at_end; clear req_cnt, rsp_cnt and words_written.
  - Next state: WRITE if ncl != 0; otherwise FENCE if fence_at_end; otherwise DONE.
  - start in any other state is ignored.
- WRITE:
  - in_ready = (words_written < ncl) & ~(ALMFULL_STALL & c1TxAlmFull). It is combinational from registered state and c1TxAlmFull.
  - On accept, next cycle: c1tx.valid=1 with sop=1, vc_sel=eVC_VA, cl_len=eCL_LEN_1, req_type=eREQ_WRLINE_I.
  - Request fields: address = base + words_written (mod 2^42, wrap permitted), mdata = words_written[15:0], data = in_data. words_written and req_cnt increment.
  - The accept of line ncl-1 moves to FENCE if fence_at_end, else DRAIN.
  - Cycles with no accept drive c1tx to all zero.
- FENCE:
  - Wait until ~(ALMFULL_STALL & c1TxAlmFull).
  - Then emit one request: valid=1, eREQ_WRFENCE, eVC_VA, mdata 0; req_cnt += 1; next state DRAIN.
- DRAIN: leave when rsp_cnt == req_cnt (registered compare, 1-cycle lag allowed), next state DONE.
- DONE: done=1 for exactly one cycle, then IDLE. words_written holds until the next start.

Responses:
- rsp_cnt increments on each c1rx.rspValid while busy.
- rspValid is ignored in IDLE.
- A response on the same cycle as the DRAIN compare is counted before the next compare.

Output latency:
- c1tx is registered, exactly 1 cycle after accept. No combinational path exists from c1rx to c1tx.

Boundary conditions:
- c1TxAlmFull rising mid-burst stops acceptance on that cycle. At most 1 request is already in the output register; the FIU's almost-full slack must absorb it.
- ncl = 0 with fence_at_end = 0 goes straight to DONE and pulses done 2 cycles after start.
- Reset mid-job returns to IDLE immediately and drops c1tx.valid. Responses still in flight are not tracked; the owner must not restart until they drain.

Test Plan:
- Basic: dst_addr=0x1000, ncl=4, no fence, in_valid always 1, no almFull -> 4 writes to 0x1000..0x1003 on consecutive cycles, mdata 0..3, data matches input; return 4 rspValid -> done pulses once; words_written=4.
- Backpressure: ncl=8, c1TxAlmFull held high for cycles 3-6 -> in_ready low in those cycles; no request issued in cycles 4-7; exactly 8 writes total; addresses contiguous.
- Fence: ncl=2, fence_at_end=1 -> 2 WrLine_I requests then 1 WrFence; done only after the 3rd rspValid; no done after just 2 responses.
- Zero length: ncl=0, fence=0 -> no c1tx.valid; done 2 cycles after start. ncl=0, fence=1 -> a single fence; done after 1 response.
- Wrap and start while busy: dst_addr=2^42-2, ncl=4 -> addresses 2^42-2, 2^42-1, 0, 1. A second start pulse mid-job is ignored (dst unchanged, no extra writes).
- Reset mid-WRITE after 3 of 8 lines -> next cycle c1tx.valid=0, busy=0, state_out=0. A new job of ncl=1 completes normally.
